// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared types and sizing helpers for the multi-channel FIR.
//   state_t        : controller state (IDLE accept / MAC serial taps / OUT hold)
//   ch_w_f         : channel-select width, never narrower than one bit
//   acc_w_f        : accumulator width, wide enough for TAPS full-scale products
//   round_const_f  : half-LSB constant added before the fractional shift
//   sat_max_f/min_f: signed output clamp bounds for a DATA_W-bit result
//   coef_reset_f   : reset coefficient bank, identity response on tap 0
package fir_mc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int DEF_DATA_W   = 24;
   localparam int DEF_COEF_W   = 24;
   localparam int DEF_FRAC_W   = 23;
   localparam int DEF_TAPS     = 8;
   localparam int DEF_CHANNELS = 2;

   function automatic int ch_w_f(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic int acc_w_f(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   localparam int DEF_CH_W  = ch_w_f(DEF_CHANNELS);
   localparam int DEF_ACC_W = acc_w_f(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

   // Constants are produced at 128 bits and narrowed by the user.
   function automatic logic signed [127:0] round_const_f(input int frac_w);
      return 128'sd1 <<< (frac_w - 1);
   endfunction

   function automatic logic signed [127:0] sat_max_f(input int data_w);
      return (128'sd1 <<< (data_w - 1)) - 128'sd1;
   endfunction

   function automatic logic signed [127:0] sat_min_f(input int data_w);
      return -(128'sd1 <<< (data_w - 1));
   endfunction

   // Tap 0 resets to +1.0, which needs one bit above COEF_W in Q1.FRAC_W.
   function automatic logic signed [127:0] coef_reset_f(input int idx, input int frac_w);
      return (idx == 0) ? (128'sd1 <<< frac_w) : 128'sd0;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round-half-up and saturate.
//   acc : signed accumulator, ACC_W bits, FRAC_W fractional bits
//   q   : signed result, DATA_W bits, clamped to the representable range
module fir_round_sat
   import fir_mc_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] q
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] RND     = SW'(round_const_f(FRAC_W));
   localparam logic signed [SW-1:0] SAT_MAX = SW'(sat_max_f(DATA_W));
   localparam logic signed [SW-1:0] SAT_MIN = SW'(sat_min_f(DATA_W));

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] shifted;

   always_comb begin
      sum     = SW'(acc) + RND;
      shifted = sum >>> FRAC_W;
      if (shifted > SAT_MAX) begin
         q = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         q = SAT_MIN[DATA_W-1:0];
      end else begin
         q = shifted[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-multiplexed multi-channel FIR with one serial MAC.
//   clk, rst              : single clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_chan : input sample stream, one channel per beat
//   m_valid/m_ready/m_data/m_chan : filtered output stream
//   coef_we/coef_addr/coef_wdata  : coefficient bank write port (IDLE only)
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; the sender holds data stable while valid is high and ready is low, and
// ready never depends combinationally on the opposite side's ready.
module fir_filter_mc
   import fir_mc_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int TAPS     = DEF_TAPS,
   parameter int CHANNELS = DEF_CHANNELS,
   localparam int CH_W    = ch_w_f(CHANNELS),
   localparam int TAP_W   = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [CH_W-1:0]   s_chan,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_chan,
   input  logic              coef_we,
   input  logic [TAP_W-1:0]  coef_addr,
   input  logic [COEF_W-1:0] coef_wdata
);

   // Coefficients carry one headroom bit so the +1.0 reset value is exact.
   localparam int CW     = COEF_W + 1;
   localparam int PROD_W = DATA_W + CW;
   localparam int ACC_W  = acc_w_f(DATA_W, COEF_W, TAPS);

   state_t                   state;
   logic [CH_W-1:0]          ch;
   logic [TAP_W-1:0]         tap;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] line [CHANNELS][TAPS];
   logic signed [CW-1:0]     coef [TAPS];
   logic [DATA_W-1:0]        m_data_r;
   logic [CH_W-1:0]          m_chan_r;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [DATA_W-1:0] sat_out;
   logic                     chan_ok;
   logic                     addr_ok;
   logic                     last_tap;

   assign chan_ok  = {1'b0, s_chan} < (CH_W + 1)'(CHANNELS);
   assign addr_ok  = {1'b0, coef_addr} < (TAP_W + 1)'(TAPS);
   assign last_tap = (tap == TAP_W'(TAPS - 1));

   // The final tap's product is folded in combinationally so the rounded
   // result can be registered on the same edge that leaves MAC.
   assign prod     = PROD_W'(coef[tap]) * PROD_W'(line[ch][tap]);
   assign acc_next = acc + ACC_W'(prod);

   fir_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_round_sat (
      .acc (acc_next),
      .q   (sat_out)
   );

   assign s_ready = (state == IDLE) && !rst;
   assign m_valid = (state == OUT);
   assign m_data  = m_data_r;
   assign m_chan  = m_chan_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ch       <= '0;
         tap      <= '0;
         acc      <= '0;
         m_data_r <= '0;
         m_chan_r <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < TAPS; k++) begin
               line[c][k] <= '0;
            end
         end
         for (int k = 0; k < TAPS; k++) begin
            coef[k] <= CW'(coef_reset_f(k, FRAC_W));
         end
      end else begin
         case (state)
            IDLE: begin
               if (coef_we && addr_ok) begin
                  coef[coef_addr] <= CW'($signed(coef_wdata));
               end
               // Out-of-range channels are consumed and dropped here.
               if (s_valid && chan_ok) begin
                  line[s_chan][0] <= s_data;
                  for (int k = 1; k < TAPS; k++) begin
                     line[s_chan][k] <= line[s_chan][k-1];
                  end
                  ch    <= s_chan;
                  acc   <= '0;
                  tap   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               if (last_tap) begin
                  m_data_r <= sat_out;
                  m_chan_r <= ch;
                  state    <= OUT;
               end else begin
                  tap <= tap + 1'b1;
               end
            end
            OUT: begin
               if (m_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_filter_mc.md
# fir_filter_mc

Multi-channel, time-multiplexed FIR filter for the codec audio path. Successor to the fixed 5-tap FIR, adding:
- parametrised taps, widths and channel count;
- one shared serial MAC;
- runtime-loadable coefficients;
- valid/ready streaming on both sides;
- rounded, saturated output.

It sits between the codec receive deserialiser and the downstream DSP/transmit stages. It processes one sample of one channel at a time.

## Interface
Parameters:
- DATA_W, 24: sample width, signed two's complement.
- COEF_W, 24: coefficient width, signed.
- FRAC_W, 23: coefficient fractional bits (Q1.23 default).
- TAPS, 8: taps per channel, ≥2.
- CHANNELS, 2: independent delay lines, ≥1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  input sample.
- s_chan  in  CH_W = max(1,$clog2(CHANNELS))  channel of s_data.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  DATA_W  filtered sample.
- m_chan  out  CH_W  channel of m_data.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index.
- coef_wdata  in  COEF_W  coefficient value.

## Operation
- Coefficient bank is shared by all channels.
- Reset values: coef[0] = 1<<FRAC_W (identity), all others 0. Delay lines all 0.
- States and transitions:
  - IDLE: s_ready=1. On s_valid, the sample is accepted. It shifts into delay line s_chan: line[s_chan][0] ← s_data, line[k] ← line[k-1]. The channel is latched, acc cleared, tap index cleared, go to MAC.
  - MAC: one tap per cycle, acc += coef[i] * line[ch][i] for i = 0..TAPS-1. After the last tap, go to OUT.
  - OUT: m_valid=1, with m_data/m_chan held stable. When m_ready=1, go to IDLE.
- Only the latched channel's delay line changes. Other channels are untouched.
- s_chan ≥ CHANNELS: the sample is accepted and dropped. No delay line changes and no output is produced; the block stays in IDLE.
- Arithmetic:
  - Product width: DATA_W+COEF_W.
  - acc width: DATA_W+COEF_W+$clog2(TAPS). The accumulator must not overflow.
  - Output = (acc + (1<<(FRAC_W-1))) >>> FRAC_W, which is round-half-up.
  - The result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Coefficient writes:
  - Applied only in IDLE, taking effect on the next accepted sample.
  - coef_we outside IDLE is ignored (dropped, not queued).
  - A write and an accepted sample in the same IDLE cycle: the sample's MAC uses the new value.
- rst in any state: IDLE, acc=0, delay lines and coefficients back to reset values, any in-flight output discarded.

## Timing
- Outputs during/after reset: s_ready=0 while rst is high, m_valid=0, m_data=0, m_chan=0.
- s_ready=1 from the first cycle after rst deasserts.
- Accept edge is T:
  - MAC occupies cycles T+1..T+TAPS.
  - m_valid rises at T+TAPS+1.
- Throughput: at most one sample per TAPS+2 cycles with m_ready tied high.
- s_ready is 0 in MAC and OUT. An upstream s_valid stays pending with data held stable; this is the upstream's duty.
- m_ready low in OUT stalls indefinitely. There is no data loss and outputs are unchanged.
- s_ready depends on registered state only. There is no combinational path from m_ready to s_ready.

## Structure
- Package fir_mc_pkg holds:
  - state enum {IDLE, MAC, OUT};
  - localparams for CH_W, ACC_W, round constant, and saturation bounds as functions of the parameters;
  - the reset coefficient function.
- Sub-module fir_round_sat: combinational round + saturate from ACC_W to DATA_W, parametrised on ACC_W/DATA_W/FRAC_W. Its output is registered into m_data on the MAC→OUT transition.
- Delay lines: register array [CHANNELS][TAPS]. Coefficients: register array [TAPS].

## Test plan
- Identity after reset, m_ready=1:
  - Stimulus: ch0 samples 0x100000, 0x7FFFFF, 0x800000.
  - Required: m_data equals input, m_chan=0, m_valid exactly TAPS+1 cycles after each accept.
- Impulse response:
  - Stimulus: load coef = 0x100000, 0x200000, 0x400000, 0x200000, 0x100000, 0… Then ch1 sends 0x400000 followed by TAPS-1 zeros.
  - Required outputs: 0x080000, 0x100000, 0x200000, 0x100000, 0x080000, 0…
- Channel isolation:
  - Stimulus: interleave ch0 = 0x200000 and ch1 = 0 with the impulse coefficients.
  - Required: ch1 outputs all 0; ch0 matches a single-channel run.
- Saturation and rounding:
  - Stimulus: all coef 0x7FFFFF with repeated 0x7FFFFF input.
  - Required: m_data clamps to 0x7FFFFF. Negative case clamps to 0x800000.
  - Rounding: coef[0] = 0x000001 with input 0x400000 gives output 1 (round-half-up).
- Backpressure and write blocking:
  - Stimulus: hold m_ready=0 for 20 cycles in OUT.
  - Required: m_data stable, s_ready=0.
  - A coef_we issued during MAC is verified not applied.
- Reset mid-MAC:
  - Stimulus: assert rst at T+3.
  - Required: m_valid never rises. The next sample after reset passes through with identity coefficients and zeroed history.
